// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared definitions for the multiplier datapath and its accumulator stage
package multiplier_pkg;
  localparam int PRODUCT_WIDTH_DEFAULT = 5;
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } accState_t;
  function automatic int sumWidth(input int productWidth, input int batchCount);
    return productWidth + $clog2(batchCount);
  endfunction
endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT successive products and hands each batch sum downstream
module product_accumulator
  import multiplier_pkg::*;
#(
  parameter int PRODUCT_WIDTH = PRODUCT_WIDTH_DEFAULT,
  parameter int COUNT = 4,
  localparam int SUM_WIDTH = sumWidth(PRODUCT_WIDTH, COUNT),
  localparam int COUNT_WIDTH = $clog2(COUNT + 1)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic [PRODUCT_WIDTH-1:0] productIn,
  input  logic                     productValid,
  output logic                     productReady,
  output logic [SUM_WIDTH-1:0]     sumOut,
  output logic                     sumValid,
  input  logic                     sumReady,
  output logic [COUNT_WIDTH-1:0]   count
);
  accState_t state;
  logic [SUM_WIDTH-1:0] acc;
  logic [SUM_WIDTH-1:0] accNext;
  logic lastProduct;
  assign accNext = acc + SUM_WIDTH'(productIn);
  assign lastProduct = count == COUNT_WIDTH'(COUNT - 1);
  assign productReady = state == ACCUM;
  // Batch FSM: accumulate in ACCUM, hold the finished sum in DONE until taken; clear overrides all
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ACCUM;
      acc      <= '0;
      count    <= '0;
      sumOut   <= '0;
      sumValid <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      count    <= '0;
      sumValid <= 1'b0;
      state    <= ACCUM;
      if (state == DONE) sumOut <= '0;
    end else if (state == DONE) begin
      if (sumReady) begin
        sumValid <= 1'b0;
        state    <= ACCUM;
      end
    end else if (productValid) begin
      if (lastProduct) begin
        sumOut   <= accNext;
        sumValid <= 1'b1;
        acc      <= '0;
        count    <= '0;
        state    <= DONE;
      end else begin
        acc   <= accNext;
        count <= count + COUNT_WIDTH'(1);
      end
    end
  end
endmodule
